neighbor_best_hop_scanner: RTL and testbench

// - Read-side companion of the neighbor table: sequentially scans the table's indexed read port and selects the best next-hop neighbor.
// - Best = valid entry with highest Q-value; own node ID is excluded.
// - Sits between the neighbor table and the routing/TX path; the TX path starts a scan, then consumes best_* on done.

---
 rtl/neighbor_best_hop_scanner.sv | 149 ++++++++++++++
 tb/tb_neighbor_best_hop_scanner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/neighbor_best_hop_scanner.sv
// Scans the neighbor table one entry per cycle and picks the eligible entry with the highest Q-value.
// Optional energy tie-break on equal Q-values is enabled by defining NT_SCAN_ENERGY_TIEBREAK_EN.
//
// state  | meaning
// S_IDLE | waiting for start; best_*/found hold the last result
// S_SCAN | evaluating entry rd_idx this cycle
// S_DONE | one-cycle done pulse, result valid
module neighbor_best_hop_scanner #(
  parameter int WORD_WIDTH  = 16,
  parameter int TABLE_DEPTH = 32,
  parameter logic [WORD_WIDTH-1:0] MY_NODE_ID = 16'h000C,
  localparam int IDX_W = $clog2(TABLE_DEPTH),
  localparam int CNT_W = $clog2(TABLE_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [CNT_W-1:0]      num_entries,
  output logic [IDX_W-1:0]      rd_idx,
  input  logic                  rd_valid,
  input  logic [WORD_WIDTH-1:0] rd_node_id,
  input  logic [WORD_WIDTH-1:0] rd_hops,
  input  logic [WORD_WIDTH-1:0] rd_qvalue,
  input  logic [WORD_WIDTH-1:0] rd_energy,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [IDX_W-1:0]      best_idx,
  output logic [WORD_WIDTH-1:0] best_id,
  output logic [WORD_WIDTH-1:0] best_hops,
  output logic [WORD_WIDTH-1:0] best_qvalue
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] n_clamp;
  logic             eligible;
  logic             better;

`ifdef NT_SCAN_ENERGY_TIEBREAK_EN
  logic [WORD_WIDTH-1:0] best_energy;

  always_comb begin
    better = !found || (rd_qvalue > best_qvalue) ||
             ((rd_qvalue == best_qvalue) && (rd_energy > best_energy));
  end
`else
  logic unused_energy;
  assign unused_energy = ^rd_energy;

  // Strict greater-than keeps the lowest-index winner on equal Q.
  always_comb begin
    better = !found || (rd_qvalue > best_qvalue);
  end
`endif

  always_comb begin
    n_clamp  = (num_entries > CNT_W'(TABLE_DEPTH)) ? CNT_W'(TABLE_DEPTH) : num_entries;
    eligible = rd_valid && (rd_node_id != MY_NODE_ID);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      rd_idx      <= '0;
      last_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      best_idx    <= '0;
      best_id     <= '0;
      best_hops   <= '0;
      best_qvalue <= '0;
`ifdef NT_SCAN_ENERGY_TIEBREAK_EN
      best_energy <= '0;
`endif
    end else if (flush) begin
      state       <= S_IDLE;
      rd_idx      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      best_idx    <= '0;
      best_id     <= '0;
      best_hops   <= '0;
      best_qvalue <= '0;
`ifdef NT_SCAN_ENERGY_TIEBREAK_EN
      best_energy <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_idx      <= '0;
            busy        <= 1'b1;
            found       <= 1'b0;
            best_idx    <= '0;
            best_id     <= '0;
            best_hops   <= '0;
            best_qvalue <= '0;
`ifdef NT_SCAN_ENERGY_TIEBREAK_EN
            best_energy <= '0;
`endif
            last_idx    <= IDX_W'(n_clamp - CNT_W'(1));
            if (n_clamp == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (eligible && better) begin
            found       <= 1'b1;
            best_idx    <= rd_idx;
            best_id     <= rd_node_id;
            best_hops   <= rd_hops;
            best_qvalue <= rd_qvalue;
`ifdef NT_SCAN_ENERGY_TIEBREAK_EN
            best_energy <= rd_energy;
`endif
          end
          if (rd_idx == last_idx) begin
            state  <= S_DONE;
            done   <= 1'b1;
            rd_idx <= '0;
          end else begin
            rd_idx <= rd_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_best_hop_scanner.sv
// Directed bench for neighbor_best_hop_scanner: a behavioural table answers rd_idx combinationally.
module tb_neighbor_best_hop_scanner;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic        flush;
  logic [5:0]  num_entries;
  logic [4:0]  rd_idx;
  logic        rd_valid;
  logic [15:0] rd_node_id, rd_hops, rd_qvalue, rd_energy;
  logic        busy, done, found;
  logic [4:0]  best_idx;
  logic [15:0] best_id, best_hops, best_qvalue;

  logic        tbl_v [32];
  logic [15:0] tbl_id [32];
  logic [15:0] tbl_hops [32];
  logic [15:0] tbl_q [32];
  logic [15:0] tbl_e [32];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rd_valid   = tbl_v[rd_idx];
  assign rd_node_id = tbl_id[rd_idx];
  assign rd_hops    = tbl_hops[rd_idx];
  assign rd_qvalue  = tbl_q[rd_idx];
  assign rd_energy  = tbl_e[rd_idx];

  neighbor_best_hop_scanner dut (
    .clk(clk), .nrst(nrst), .start(start), .flush(flush), .num_entries(num_entries),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_node_id(rd_node_id), .rd_hops(rd_hops),
    .rd_qvalue(rd_qvalue), .rd_energy(rd_energy), .busy(busy), .done(done), .found(found),
    .best_idx(best_idx), .best_id(best_id), .best_hops(best_hops), .best_qvalue(best_qvalue)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 32; i++) begin
      tbl_v[i] = 1'b0; tbl_id[i] = '0; tbl_hops[i] = '0; tbl_q[i] = '0; tbl_e[i] = '0;
    end
  endtask

  task automatic set_ent(input int idx, input logic v, input logic [15:0] id,
                         input logic [15:0] q, input logic [15:0] e);
    tbl_v[idx] = v; tbl_id[idx] = id; tbl_q[idx] = q; tbl_e[idx] = e;
    tbl_hops[idx] = 16'(idx + 1);
  endtask

  // lat counts cycles from the start cycle (=0) to the done cycle; -1 if done never arrives
  task automatic run_scan(input logic [5:0] n, output int lat);
    @(posedge clk); #1;
    num_entries = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  int lat, first, cnt;

  initial begin
    nrst = 1'b0; start = 1'b0; flush = 1'b0; num_entries = '0;
    clear_table();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_best_idx", best_idx, 0);
    chk("rst_best_id", best_id, 0);
    chk("rst_best_q", best_qvalue, 0);
    nrst = 1'b1;

    // Basic scan: highest valid Q wins, invalid Q=99 ignored
    set_ent(0, 1, 16'd3, 16'd10, 0);
    set_ent(1, 1, 16'd5, 16'd40, 0);
    set_ent(2, 1, 16'd7, 16'd25, 0);
    set_ent(3, 0, 16'd9, 16'd99, 0);
    run_scan(6'd4, lat);
    chk("a_lat", lat, 5);
    chk("a_found", found, 1);
    chk("a_best_idx", best_idx, 1);
    chk("a_best_id", best_id, 5);
    chk("a_best_hops", best_hops, 2);
    chk("a_best_q", best_qvalue, 40);
    @(posedge clk); #1;
    chk("a_done_pulse", done, 0);
    chk("a_busy_after", busy, 0);

    // Own ID excluded even with the highest Q
    clear_table();
    set_ent(0, 1, 16'd2, 16'd20, 0);
    set_ent(1, 1, 16'h000C, 16'd90, 0);
    set_ent(2, 1, 16'd4, 16'd30, 0);
    run_scan(6'd3, lat);
    chk("b_lat", lat, 4);
    chk("b_best_q", best_qvalue, 30);
    chk("b_best_idx", best_idx, 2);
    chk("b_best_id", best_id, 4);

    clear_table();
    set_ent(0, 0, 16'd2, 16'd20, 0);
    set_ent(1, 0, 16'd3, 16'd90, 0);
    set_ent(2, 0, 16'd4, 16'd30, 0);
    run_scan(6'd3, lat);
    chk("c_found", found, 0);
    chk("c_best_q", best_qvalue, 0);
    chk("c_best_id", best_id, 0);
    chk("c_best_idx", best_idx, 0);

    // Empty scan
    run_scan(6'd0, lat);
    chk("z_lat", lat, 1);
    chk("z_found", found, 0);
    chk("z_busy", busy, 1);
    @(posedge clk); #1;
    chk("z_busy_after", busy, 0);
    chk("z_done_after", done, 0);

    // Clamp 40 -> 32 entries
    clear_table();
    for (int i = 0; i < 32; i++) set_ent(i, 1, 16'(16'h0100 + i), 16'(i), 0);
    run_scan(6'd40, lat);
    chk("cl_lat", lat, 33);
    chk("cl_best_idx", best_idx, 31);
    chk("cl_best_id", best_id, 16'h011F);

    // Flush on the 2nd scan cycle of an N=8 scan
    clear_table();
    set_ent(0, 1, 16'd3, 16'd10, 0);
    set_ent(1, 1, 16'd5, 16'd40, 0);
    set_ent(2, 1, 16'd7, 16'd25, 0);
    @(posedge clk); #1;
    num_entries = 6'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("f_busy", busy, 0);
    chk("f_found", found, 0);
    chk("f_rd_idx", rd_idx, 0);
    cnt = 0;
    repeat (12) begin
      if (done) cnt++;
      @(posedge clk); #1;
    end
    chk("f_no_done", cnt, 0);
    run_scan(6'd8, lat);
    chk("f_rescan_lat", lat, 9);
    chk("f_rescan_idx", best_idx, 1);
    chk("f_rescan_q", best_qvalue, 40);

    // Second start while busy is ignored
    @(posedge clk); #1;
    num_entries = 6'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; first = -1; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        cnt++;
        if (first < 0) first = lat;
      end
      start = (lat == 3);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("s_done_lat", first, 7);
    chk("s_done_cnt", cnt, 1);

    // flush and start together in IDLE
    @(posedge clk); #1;
    num_entries = 6'd4; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("fs_busy", busy, 0);
    cnt = 0;
    repeat (8) begin
      if (done || busy) cnt++;
      @(posedge clk); #1;
    end
    chk("fs_idle", cnt, 0);

    // Equal-Q tie-break
    clear_table();
    set_ent(0, 1, 16'h21, 16'd10, 16'd500);
    set_ent(2, 1, 16'h22, 16'd50, 16'd100);
    set_ent(5, 1, 16'h25, 16'd50, 16'd200);
    set_ent(6, 1, 16'h26, 16'd49, 16'd900);
    run_scan(6'd8, lat);
    chk("t_best_q", best_qvalue, 50);
`ifdef NT_SCAN_ENERGY_TIEBREAK_EN
    chk("t_best_idx", best_idx, 5);
`else
    chk("t_best_idx", best_idx, 2);
`endif

    // Async reset mid-scan
    @(posedge clk); #1;
    num_entries = 6'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_found", found, 0);
    chk("ar_rd_idx", rd_idx, 0);
    chk("ar_best_q", best_qvalue, 0);
    @(posedge clk); #1;
    nrst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
